// File: rtl/chord_pkg.sv
// Shared widths, semitone step table and waveform helpers for the chord player.
// CHORD_HARMONIC_EN (see chord_voice) adds a second-harmonic partial per voice.
package chord_pkg;

  localparam int unsigned NOTE_W     = 6;
  localparam int unsigned DUR_W      = 6;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned PHASE_BITS = 20;
  localparam int unsigned STEP_W     = 11;

  // round(2^20 * 27.5 * 2^(k/12) / 48000) for the lowest octave
  localparam logic [STEP_W-1:0] BASE_STEP [12] = '{
    11'd601, 11'd636, 11'd674, 11'd714, 11'd757, 11'd802,
    11'd850, 11'd900, 11'd954, 11'd1010, 11'd1070, 11'd1134
  };

  function automatic logic [PHASE_BITS-1:0] note_step(input logic [NOTE_W-1:0] note);
    logic [NOTE_W-1:0] n;
    logic [2:0]        octave;
    logic [3:0]        semitone;
    n        = note - 1'b1;
    octave   = 3'(n / NOTE_W'(12));
    semitone = 4'(n % NOTE_W'(12));
    return {{(PHASE_BITS - STEP_W){1'b0}}, BASE_STEP[semitone]} << octave;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] triangle(input logic [PHASE_BITS-1:0] phase);
    logic [SAMPLE_W-1:0] t;
    t = phase[PHASE_BITS-2 -: SAMPLE_W];
    if (phase[PHASE_BITS-1]) t = ~t;
    return signed'(t ^ {1'b1, {(SAMPLE_W - 1){1'b0}}});
  endfunction

endpackage

// File: rtl/chord_voice.sv
// One voice slot: busy flag, note, beat countdown, phase accumulator and sample.
// With CHORD_HARMONIC_EN defined the sample blends the fundamental with its octave.
module chord_voice
  import chord_pkg::*;
#(
  parameter int unsigned PHASE_W = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_i,
  input  logic [NOTE_W-1:0]          note_i,
  input  logic [DUR_W-1:0]           dur_i,
  input  logic                       beat_i,
  input  logic                       advance_i,
  output logic                       busy_o,
  output logic                       busy_next_o,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  logic               busy_q, busy_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               sounding;
  logic signed [SAMPLE_W-1:0] fund;

  assign sounding = busy_q && (note_q != '0);

  always_comb begin
    busy_d  = busy_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      busy_d  = 1'b1;
      note_d  = note_i;
      cnt_d   = dur_i;
      phase_d = '0;
    end else if (busy_q) begin
      if (beat_i) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DUR_W'(1)) busy_d = 1'b0;
      end
      if (advance_i && sounding) phase_d = phase_q + PHASE_W'(note_step(note_q));
    end
  end

  // Tone is read from the post-advance phase so the sample matches this request
  assign fund = triangle(phase_d[PHASE_W-1 -: PHASE_BITS]);

`ifdef CHORD_HARMONIC_EN
  logic signed [SAMPLE_W-1:0] harm;
  assign harm     = triangle({phase_d[PHASE_W-2 -: PHASE_BITS-1], 1'b0});
  assign sample_o = sounding ? (fund >>> 1) + (harm >>> 2) : '0;
`else
  assign sample_o = sounding ? fund : '0;
`endif

  assign busy_o      = busy_q;
  assign busy_next_o = busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      note_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      busy_q  <= busy_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/chord_player.sv
// Three-voice chord player: slot allocation, expiry pulse, mix and attenuation.
// Voice timbre depends on CHORD_HARMONIC_EN inside chord_voice; the mix is unchanged.
module chord_player
  import chord_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned PHASE_W    = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       play_enable_i,
  input  logic                       activate_i,
  input  logic [NOTE_W-1:0]          note_to_load_i,
  input  logic [DUR_W-1:0]           duration_i,
  input  logic                       load_new_note_i,
  input  logic                       beat_i,
  input  logic                       generate_next_sample_i,
  input  logic [1:0]                 weight_i,
  output logic signed [SAMPLE_W-1:0] final_sample_o,
  output logic                       note_done_o,
  output logic                       sample_ready_o
);

  localparam int unsigned MIX_W = SAMPLE_W + 2;

  logic                       running, accept, beat_run, load_req, found;
  logic [NUM_VOICES-1:0]      busy, busy_next, load_vec;
  logic signed [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
  logic signed [MIX_W-1:0]    mix_sum, mix_shift;
  logic signed [SAMPLE_W-1:0] final_q, final_d;
  logic                       ready_q, done_q, done_d;

  assign running  = play_enable_i & activate_i;
  assign accept   = running & generate_next_sample_i;
  assign beat_run = running & beat_i;
  assign load_req = load_new_note_i && (duration_i != '0);

  // Lowest slot idle before this edge wins; a slot expiring now is not yet free
  always_comb begin
    load_vec = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (load_req && !busy[i] && !found) begin
        load_vec[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    chord_voice #(
      .PHASE_W(PHASE_W)
    ) u_voice (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load_vec[g]),
      .note_i     (note_to_load_i),
      .dur_i      (duration_i),
      .beat_i     (beat_run),
      .advance_i  (accept),
      .busy_o     (busy[g]),
      .busy_next_o(busy_next[g]),
      .sample_o   (voice_sample[g])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + MIX_W'(voice_sample[i]);
    end
    mix_shift = (mix_sum >>> 2) >>> weight_i;
    final_d   = accept ? SAMPLE_W'(mix_shift) : final_q;
    done_d    = (|busy) & ~(|busy_next);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      final_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      final_q <= final_d;
      ready_q <= accept;
      done_q  <= done_d;
    end
  end

  assign final_sample_o = final_q;
  assign sample_ready_o = ready_q;
  assign note_done_o    = done_q;

endmodule

// File: tb/tb_chord_player.sv
// Scoreboard bench for chord_player: a slot-level reference model predicts every edge,
// a monitor compares strobes, held samples and note_done. Honors CHORD_HARMONIC_EN.
module tb_chord_player;

  localparam int NV     = 3;
  localparam int PH_MOD = 1 << 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              play_enable = 1'b0, activate = 1'b0, load_new_note = 1'b0;
  logic              beat = 1'b0, gen = 1'b0;
  logic [5:0]        note_to_load = '0, duration = '0;
  logic [1:0]        weight = '0;
  logic signed [15:0] final_sample;
  logic              note_done, sample_ready;

  always #5 clk = ~clk;

  chord_player dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .play_enable_i         (play_enable),
    .activate_i            (activate),
    .note_to_load_i        (note_to_load),
    .duration_i            (duration),
    .load_new_note_i       (load_new_note),
    .beat_i                (beat),
    .generate_next_sample_i(gen),
    .weight_i              (weight),
    .final_sample_o        (final_sample),
    .note_done_o           (note_done),
    .sample_ready_o        (sample_ready)
  );

  typedef struct {int at_cyc; bit ready; bit done; int fin;} ctl_t;

  int   checks = 0, errors = 0, cyc = 0, done_seen = 0;
  ctl_t ctl_q[$];
  int   sample_q[$];
  bit   capture = 1'b0;
  int   cap[$], cap0[$], cap3[$];

  bit m_busy [NV];
  int m_note [NV], m_cnt [NV], m_phase [NV];
  int m_final = 0;
  int base_step [12];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int model_step(input int nt);
    int n;
    n = nt - 1;
    return base_step[n % 12] << (n / 12);
  endfunction

  function automatic int tri_val(input int ph);
    int t;
    t = (ph >> 3) & 'hFFFF;
    if (((ph >> 19) & 1) != 0) t = 'hFFFF - t;
    return t - 32768;
  endfunction

  function automatic int voice_val(input int ph);
`ifdef CHORD_HARMONIC_EN
    int f, h;
    f = tri_val(ph);
    h = tri_val((ph * 2) % PH_MOD);
    return (f >>> 1) + (h >>> 2);
`else
    return tri_val(ph);
`endif
  endfunction

  // Predict the coming edge from the inputs currently driven, then clock it
  task automatic tick();
    bit   run, acc, any_pre, any_post;
    int   mix, slot;
    ctl_t e;
    rst_n    = 1'b1;
    run      = play_enable && activate;
    acc      = run && gen;
    mix      = 0;
    slot     = -1;
    any_pre  = 1'b0;
    any_post = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (m_busy[v]) any_pre = 1'b1;
      else if (slot < 0) slot = v;
    end
    for (int v = 0; v < NV; v++) begin
      if (acc && m_busy[v] && m_note[v] != 0) begin
        m_phase[v] = (m_phase[v] + model_step(m_note[v])) % PH_MOD;
        mix += voice_val(m_phase[v]);
      end
    end
    if (run && beat) begin
      for (int v = 0; v < NV; v++) begin
        if (m_busy[v]) begin
          m_cnt[v]--;
          if (m_cnt[v] == 0) m_busy[v] = 1'b0;
        end
      end
    end
    if (load_new_note && duration != 0 && slot >= 0) begin
      m_busy[slot]  = 1'b1;
      m_note[slot]  = int'(note_to_load);
      m_cnt[slot]   = int'(duration);
      m_phase[slot] = 0;
    end
    for (int v = 0; v < NV; v++) if (m_busy[v]) any_post = 1'b1;
    if (acc) begin
      m_final = (mix >>> 2) >>> int'(weight);
      sample_q.push_back(m_final);
    end
    e.at_cyc = cyc + 1;
    e.ready  = acc;
    e.done   = any_pre && !any_post;
    e.fin    = m_final;
    ctl_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    load_new_note = 1'b0;
    beat = 1'b0;
    gen = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_busy[v] = 1'b0; m_note[v] = 0; m_cnt[v] = 0; m_phase[v] = 0;
    end
    m_final = 0;
    ctl_q.delete();
    sample_q.delete();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_note(input int nt, input int d);
    note_to_load  = 6'(nt);
    duration      = 6'(d);
    load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic run_cycles(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      beat = (period > 0) && (i % period == period - 1);
      tick();
    end
    beat = 1'b0;
  endtask

  // Monitor: outputs of edge k are sampled 2 time units after it
  initial begin
    ctl_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        chk("reset_final", final_sample, 0);
        chk("reset_ready", sample_ready, 0);
        chk("reset_done", note_done, 0);
      end else if (ctl_q.size() > 0 && ctl_q[0].at_cyc == cyc) begin
        e = ctl_q.pop_front();
        chk("sample_ready", sample_ready, e.ready);
        chk("note_done", note_done, e.done);
        if (sample_ready) begin
          if (sample_q.size() == 0) chk("unexpected_sample", 1, 0);
          else chk("sample", final_sample, sample_q.pop_front());
          if (capture) cap.push_back(int'(final_sample));
        end else begin
          chk("held_sample", final_sample, e.fin);
        end
        if (note_done) done_seen++;
      end else begin
        chk("idle_ready", sample_ready, 0);
        chk("idle_done", note_done, 0);
      end
    end
  end

  initial begin
    int d0;
    for (int k = 0; k < 12; k++)
      base_step[k] = $rtoi(2.0 ** 20 * 27.5 * 2.0 ** (real'(k) / 12.0) / 48000.0 + 0.5);
    apply_reset(3);

    // Chord loaded while inactive, then released with continuous requests
    weight = 2'd2; play_enable = 1'b1; activate = 1'b0;
    load_note(36, 12); load_note(32, 12); load_note(26, 12);
    activate = 1'b1; gen = 1'b1;
    d0 = done_seen;
    run_cycles(60, 4);
    run_cycles(2, 0);
    chk("chord_done_count", done_seen - d0, 1);

    // Staggered durations; reload into the lowest freed slot
    apply_reset(2);
    weight = 2'd0; play_enable = 1'b1; activate = 1'b1; gen = 1'b1;
    load_note(40, 20); load_note(28, 8); load_note(50, 4);
    d0 = done_seen;
    run_cycles(24, 3);
    chk("stagger_no_early_done", done_seen - d0, 0);
    load_note(32, 6);
    run_cycles(42, 3);
    run_cycles(2, 0);
    chk("stagger_done_count", done_seen - d0, 1);

    // Fourth load with every slot busy must be ignored
    apply_reset(2);
    weight = 2'd1;
    load_note(13, 10); load_note(25, 10); load_note(37, 10);
    load_note(20, 5);
    d0 = done_seen;
    run_cycles(44, 4);
    run_cycles(2, 0);
    chk("full_done_count", done_seen - d0, 1);

    // Same note at weight 0 and weight 3
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset(2);
      weight = (pass == 0) ? 2'd0 : 2'd3;
      gen = 1'b0;
      load_note(44, 63);
      cap.delete();
      capture = 1'b1; gen = 1'b1;
      run_cycles(40, 0);
      gen = 1'b0;
      tick();
      capture = 1'b0;
      if (pass == 0) cap0 = cap; else cap3 = cap;
    end
    chk("weight_cap_len0", cap0.size(), 40);
    chk("weight_cap_len3", cap3.size(), 40);
    for (int i = 0; i < 40 && i < cap0.size() && i < cap3.size(); i++)
      chk("weight_ratio", cap3[i], cap0[i] >>> 3);

    // Freeze via play_enable then activate; a load still lands while frozen
    apply_reset(2);
    weight = 2'd1; gen = 1'b1;
    load_note(30, 30); load_note(45, 30);
    run_cycles(20, 4);
    play_enable = 1'b0;
    run_cycles(50, 4);
    load_note(50, 5);
    run_cycles(50, 4);
    play_enable = 1'b1;
    run_cycles(30, 4);
    activate = 1'b0;
    run_cycles(100, 4);
    activate = 1'b1;
    d0 = done_seen;
    run_cycles(120, 4);
    run_cycles(2, 0);
    chk("freeze_done_count", done_seen - d0, 1);

    // Reset mid-note silences without a done pulse
    load_note(22, 40); load_note(0, 40);
    run_cycles(20, 4);
    d0 = done_seen;
    apply_reset(3);
    gen = 1'b1;
    run_cycles(10, 4);
    chk("reset_no_done", done_seen - d0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset(2);
      play_enable   = ($urandom_range(0, 9) != 0);
      activate      = ($urandom_range(0, 9) != 0);
      load_new_note = ($urandom_range(0, 5) == 0);
      note_to_load  = 6'($urandom_range(0, 63));
      duration      = 6'($urandom_range(0, 8));
      beat          = ($urandom_range(0, 2) == 0);
      gen           = ($urandom_range(0, 3) != 0);
      weight        = 2'($urandom_range(0, 3));
      tick();
    end
    load_new_note = 1'b0; beat = 1'b0; gen = 1'b0;
    run_cycles(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chord_player.md
Name: chord_player

Overview:
- Three-voice chord synthesizer.
- Notes load one at a time into free voice slots. Each voice plays a triangle tone for a duration counted in beats, and the voices are mixed and attenuated into one 16-bit signed sample per request.
- Sits between the song/note sequencer (note, duration, load, beat) and the codec sample path (generate_next_sample / sample_ready).

Parameters:
- NUM_VOICES, 3, number of voice slots (design verified at 3 only).
- PHASE_W, 20, phase accumulator width per voice.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_enable  in  1  global run enable; 0 freezes all voices
- activate  in  1  chord run enable; 0 freezes all voices (loading still allowed)
- note_to_load  in  6  note number; 0 = rest, 1..63 = pitch
- duration  in  6  note length in beats (1/48 measure)
- load_new_note  in  1  level; each cycle high loads one note
- beat  in  1  one-cycle beat tick from the beat generator
- generate_next_sample  in  1  sample request (level, sampled every cycle)
- weight  in  2  output attenuation, arithmetic right shift 0..3
- final_sample  out  16  signed mixed sample
- note_done  out  1  one-cycle pulse when the last busy voice finishes
- sample_ready  out  1  one-cycle strobe: final_sample updated

Behaviour:
- Reset (async, reset=0):
  - all slots idle; phases, counters and notes cleared
  - final_sample=0, sample_ready=0, note_done=0
- Running means play_enable && activate.

Load:
- On any clk edge with load_new_note=1 and duration!=0, the note goes into the lowest-index slot that is idle at that edge.
- The slot becomes busy: note stored, counter=duration, phase=0.
- If no slot is idle, or duration=0, the load is ignored.
- A slot expiring on the same edge is not eligible until the next cycle.

Duration:
- On beat=1 while running, each busy slot's counter decrements.
- A slot whose counter goes 1->0 becomes idle at that edge, so duration d lasts exactly d beats.

note_done:
- Asserted for one cycle on the edge where the busy-slot count goes from >0 to 0 by expiry.
- Never asserted by reset.

Voice tone:
- n = note-1; octave = n/12 (0..5); semitone = n%12.
- step = BASE_STEP[semitone] << octave.
- BASE_STEP[k] = round(2^20 * 27.5 * 2^(k/12) / 48000); k=0 gives 601.
- On each accepted sample request (running && generate_next_sample), a busy, non-rest voice does phase += step, mod 2^PHASE_W.
- Voice output is taken from the updated phase:
  - t = phase[18:3]
  - tri = phase[19] ? ~t : t
  - sample = tri ^ 16'h8000, as signed
- Idle or rest voices contribute 0.

Mix:
- 18-bit signed sum of the 3 voice samples.
- Result = (sum >>> 2) >>> weight, truncated to 16 bits (cannot overflow).

Sample handshake:
- Latency 1 cycle: the edge after an accepted request updates final_sample and pulses sample_ready.
- Requests while not running are ignored: no strobe, final_sample held.

Freeze:
- While not running, phases, counters and final_sample hold.
- Beats are ignored while not running.
- Loads still occur.

Reset mid-note:
- Immediately silences all voices.
- No note_done pulse.

Optional Feature:
- Macro CHORD_HARMONIC_EN.
- Defined: each voice sample = (fund >>> 1) + (h2 >>> 2), where h2 is the same triangle formula applied to phase<<1.
- Undefined: voice sample = fund only.
- The mix path is identical in both builds.

Decomposition:
- Package chord_pkg holds:
  - BASE_STEP[12] constant array
  - NOTE_W=6, DUR_W=6, SAMPLE_W=16
  - the triangle function
- Natural sub-module chord_voice (one slot): busy flag, note, duration counter, phase accumulator, voice sample.
- The top module does slot allocation, note_done, mixing, weight shift and sample_ready.

Test Plan:
- Reset: assert reset=0 mid-play -> final_sample=0, sample_ready=0, all slots idle, no note_done.
- Three loads (notes 36/32/26, duration 12) with activate=0, then activate=1 and generate_next_sample held high:
  - sample_ready high every cycle from the second cycle
  - note_done pulses once, exactly after the 12th beat
- Different durations 20/8/4, weight=0:
  - slot2 idles after 4 beats, slot1 after 8
  - a new load (note 32, duration 6) lands in slot 1 (lowest idle)
  - note_done only after the last slot expires
- Fourth load while all 3 slots are busy -> ignored; slot contents unchanged.
- Single note 44, weight 0 vs weight 3 -> final_sample magnitude ratio 8, with the same phase sequence.
- play_enable=0 or activate=0 for 1000 ns during play -> no sample_ready, counters and final_sample frozen, beats ignored; playback resumes unchanged afterwards.
